// File: rtl/llr_lrp_seq_ctrl.sv
// Frame sequencer for the Chase-style BCH soft-input path: accepts one codeword of LLRs,
// registers their magnitudes and tracks the two least-reliable positions.
module llr_lrp_seq_ctrl #(
  parameter int LLR_LEN  = 4,
  parameter int CODE_LEN = 255,
  parameter int IDX_W    = 8
) (
  input  logic               clk,
  input  logic               in_ctr_Srst_n,
  input  logic               in_ctr_start,
  input  logic               in_llr_valid,
  input  logic [LLR_LEN-1:0] in_llr,
  output logic               out_llr_ready,
  output logic               out_busy,
  output logic               out_done,
  output logic [IDX_W-1:0]   out_lrp0_idx,
  output logic [LLR_LEN-2:0] out_lrp0_mag,
  output logic [IDX_W-1:0]   out_lrp1_idx,
  output logic [LLR_LEN-2:0] out_lrp1_mag
);

  localparam int MAG_W = LLR_LEN - 1;
  localparam logic [MAG_W-1:0] MAG_ONES = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0] MAG_ONE  = MAG_W'(1);
  localparam logic [MAG_W-1:0] MAG_ZERO = {MAG_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Most-negative input has no positive counterpart, so it saturates to all ones.
  function automatic logic [MAG_W-1:0] llr_mag(input logic [LLR_LEN-1:0] llr);
    logic [MAG_W-1:0] low;
    low = llr[MAG_W-1:0];
    if (!llr[LLR_LEN-1]) begin
      llr_mag = low;
    end else if (low != MAG_ZERO) begin
      llr_mag = (~low) + MAG_ONE;
    end else begin
      llr_mag = MAG_ONES;
    end
  endfunction

  state_t           state_q;
  logic             ready_q, busy_q, done_q;
  logic [IDX_W-1:0] beat_q;
  logic [MAG_W-1:0] mag_q;
  logic [IDX_W-1:0] idx_q;
  logic             upd_q;
  logic [IDX_W-1:0] lrp0_idx_q, lrp1_idx_q;
  logic [MAG_W-1:0] lrp0_mag_q, lrp1_mag_q;
  logic             lrp0_full_q, lrp1_full_q;

  logic             accept_d;
  logic             start_d;
  logic [MAG_W-1:0] mag_d;

  assign accept_d = in_llr_valid & ready_q;
  assign start_d  = in_ctr_start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign mag_d    = llr_mag(in_llr);

  // Sequencer, magnitude stage and two-entry sorter; the frame-start clear comes last so it wins.
  always_ff @(posedge clk) begin
    if (!in_ctr_Srst_n) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beat_q      <= IDX_ZERO;
      mag_q       <= MAG_ONES;
      idx_q       <= IDX_ZERO;
      upd_q       <= 1'b0;
      lrp0_idx_q  <= IDX_ZERO;
      lrp0_mag_q  <= MAG_ONES;
      lrp0_full_q <= 1'b0;
      lrp1_idx_q  <= IDX_ZERO;
      lrp1_mag_q  <= MAG_ONES;
      lrp1_full_q <= 1'b0;
    end else begin
      if (accept_d) begin
        mag_q <= mag_d;
        idx_q <= beat_q;
      end
      upd_q <= accept_d;

      // Strict compares keep the lower index ahead on equal magnitudes.
      if (upd_q) begin
        if (!lrp0_full_q || (mag_q < lrp0_mag_q)) begin
          lrp1_idx_q  <= lrp0_idx_q;
          lrp1_mag_q  <= lrp0_mag_q;
          lrp1_full_q <= lrp0_full_q;
          lrp0_idx_q  <= idx_q;
          lrp0_mag_q  <= mag_q;
          lrp0_full_q <= 1'b1;
        end else if (!lrp1_full_q || (mag_q < lrp1_mag_q)) begin
          lrp1_idx_q  <= idx_q;
          lrp1_mag_q  <= mag_q;
          lrp1_full_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_LOAD: begin
          if (accept_d) begin
            if (beat_q == IDX_LAST) begin
              state_q <= ST_DRAIN;
              ready_q <= 1'b0;
            end else begin
              beat_q <= beat_q + IDX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (start_d) begin
        state_q     <= ST_LOAD;
        ready_q     <= 1'b1;
        busy_q      <= 1'b1;
        beat_q      <= IDX_ZERO;
        mag_q       <= MAG_ONES;
        upd_q       <= 1'b0;
        lrp0_idx_q  <= IDX_ZERO;
        lrp0_mag_q  <= MAG_ONES;
        lrp0_full_q <= 1'b0;
        lrp1_idx_q  <= IDX_ZERO;
        lrp1_mag_q  <= MAG_ONES;
        lrp1_full_q <= 1'b0;
      end
    end
  end

  assign out_llr_ready = ready_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_lrp0_idx  = lrp0_idx_q;
  assign out_lrp0_mag  = lrp0_mag_q;
  assign out_lrp1_idx  = lrp1_idx_q;
  assign out_lrp1_mag  = lrp1_mag_q;

endmodule

// File: tb/tb_llr_lrp_seq_ctrl.sv
// Directed bench for llr_lrp_seq_ctrl with CODE_LEN=8: expected LRP results are queued
// when a frame is driven and compared when the done pulse appears.
module tb_llr_lrp_seq_ctrl;

  localparam int LLR_LEN  = 4;
  localparam int CODE_LEN = 8;
  localparam int IDX_W    = 8;

  typedef struct packed {
    logic [IDX_W-1:0] i0;
    logic [2:0]       m0;
    logic [IDX_W-1:0] i1;
    logic [2:0]       m1;
  } res_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               valid;
  logic [LLR_LEN-1:0] llr;
  logic               ready, busy, done;
  logic [IDX_W-1:0]   lrp0_idx, lrp1_idx;
  logic [2:0]         lrp0_mag, lrp1_mag;

  res_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  always #5 clk = ~clk;

  llr_lrp_seq_ctrl #(.LLR_LEN(LLR_LEN), .CODE_LEN(CODE_LEN), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .in_ctr_Srst_n(rst_n),
    .in_ctr_start (start),
    .in_llr_valid (valid),
    .in_llr       (llr),
    .out_llr_ready(ready),
    .out_busy     (busy),
    .out_done     (done),
    .out_lrp0_idx (lrp0_idx),
    .out_lrp0_mag (lrp0_mag),
    .out_lrp1_idx (lrp1_idx),
    .out_lrp1_mag (lrp1_mag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_mag(input logic [3:0] l);
    int v;
    v = int'($signed(l));
    if (v < 0) v = -v;
    if (v > 7) v = 7;
    return v[2:0];
  endfunction

  // Reference: smallest magnitude (lowest index on ties), then smallest among the rest.
  function automatic res_t model(input logic [31:0] d);
    logic [2:0] m[CODE_LEN];
    int b0, b1;
    res_t r;
    for (int k = 0; k < CODE_LEN; k++) m[k] = ref_mag(d[4*k +: 4]);
    b0 = 0;
    for (int k = 1; k < CODE_LEN; k++) if (m[k] < m[b0]) b0 = k;
    b1 = (b0 == 0) ? 1 : 0;
    for (int k = 0; k < CODE_LEN; k++) if (k != b0 && m[k] < m[b1]) b1 = k;
    r.i0 = b0[IDX_W-1:0];
    r.m0 = m[b0];
    r.i1 = b1[IDX_W-1:0];
    r.m1 = m[b1];
    return r;
  endfunction

  // Scoreboard side: each done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      res_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_lrp0_idx", 32'(lrp0_idx), 32'(e.i0));
        chk("sb_lrp0_mag", 32'(lrp0_mag), 32'(e.m0));
        chk("sb_lrp1_idx", 32'(lrp1_idx), 32'(e.i1));
        chk("sb_lrp1_mag", 32'(lrp1_mag), 32'(e.m1));
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", 32'(ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
  endtask

  task automatic send_beats(input logic [31:0] d, input int n, input int gap_at,
                            input int gap_n, input bit mid_start);
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        valid = 1'b0;
        for (int g = 0; g < gap_n; g++) begin
          @(negedge clk);
          chk("gap_ready", 32'(ready), 32'd1);
        end
      end
      llr   = d[4*k +: 4];
      valid = 1'b1;
      start = mid_start && (k == 3);
      @(negedge clk);
      start = 1'b0;
      chk("load_busy", 32'(busy), 32'd1);
    end
  endtask

  // Called one half-cycle after the last accept; ends in the DONE cycle.
  task automatic finish_frame(input bit hold_valid);
    valid = hold_valid;
    chk("drain_done", 32'(done), 32'd0);
    chk("drain_ready", 32'(ready), 32'd0);
    chk("drain_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_ready", 32'(ready), 32'd0);
  endtask

  task automatic run_frame(input logic [31:0] d, input int gap_at, input int gap_n,
                           input bit mid_start, input bit hold_valid);
    sb.push_back(model(d));
    exp_done++;
    do_start();
    send_beats(d, CODE_LEN, gap_at, gap_n, mid_start);
    finish_frame(hold_valid);
  endtask

  task automatic idle_step();
    valid = 1'b0;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_res(input string tag, input int i0, input int m0, input int i1, input int m1);
    chk({tag, "_lrp0_idx"}, 32'(lrp0_idx), 32'(i0));
    chk({tag, "_lrp0_mag"}, 32'(lrp0_mag), 32'(m0));
    chk({tag, "_lrp1_idx"}, 32'(lrp1_idx), 32'(i1));
    chk({tag, "_lrp1_mag"}, 32'(lrp1_mag), 32'(m1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    llr   = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_res("rst", 0, 7, 0, 7);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous frame: magnitudes 5,2,3,7,1,1,6,4
    run_frame(32'h46F183E5, -1, 0, 1'b0, 1'b0);
    idle_step();
    chk_res("t1", 4, 1, 5, 1);

    // Same data with a 3-cycle valid gap before beat 3
    run_frame(32'h46F183E5, 3, 3, 1'b0, 1'b0);
    idle_step();
    chk_res("t2", 4, 1, 5, 1);

    // Most-negative values saturate; ties keep the first two indices
    run_frame(32'h88888888, -1, 0, 1'b0, 1'b0);
    idle_step();
    chk_res("t3", 0, 7, 1, 7);

    // Reset in the middle of a frame discards it
    do_start();
    send_beats(32'h11111111, 5, -1, 0, 1'b0);
    rst_n = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk_res("mid_rst", 0, 7, 0, 7);
    idle_step();
    run_frame(32'h76543276, -1, 0, 1'b0, 1'b0);
    idle_step();
    chk_res("t4", 2, 2, 3, 3);

    // Start during LOAD is ignored; valid held through DRAIN/DONE; start in DONE chains a frame
    run_frame(32'h46F183E5, -1, 0, 1'b1, 1'b1);
    sb.push_back(model(32'h22222222));
    exp_done++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    chk("chain_ready", 32'(ready), 32'd1);
    chk("chain_busy", 32'(busy), 32'd1);
    send_beats(32'h22222222, CODE_LEN, -1, 0, 1'b0);
    finish_frame(1'b0);
    idle_step();
    chk_res("t5", 0, 2, 1, 2);

    // Valid in IDLE is ignored and results hold
    valid = 1'b1;
    llr   = 4'h1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_valid_ready", 32'(ready), 32'd0);
      chk_res("t6", 0, 2, 1, 2);
    end
    valid = 1'b0;

    // A few random frames against the reference
    for (int r = 0; r < 3; r++) begin
      run_frame($urandom(), (r == 1) ? 5 : -1, 2, 1'b0, 1'b0);
      idle_step();
    end

    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'(exp_done));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
